sim_test_monitor: RTL and testbench
===================================

# sim_test_monitor

Parametrised end-of-test monitor for the Verilator/RTL simulation top of the tinyriscv SoC. It watches one "done" and one "pass" value per hart or channel, typically GPR x26/x27 tapped hierarchically. It filters them through a settle window and runs a watchdog timeout. It reports a single sticky PASS/FAIL/TIMEOUT verdict plus a finish request for the C++ harness. It replaces the ad-hoc single-hart compare-and-print logic in the bench top.

## Interface

Parameters:
- NUM_CH, 1: number of monitored channels (harts).
- DATA_W, 32: width of monitored values.
- DONE_VALUE, 1: value on done_val_i[i] meaning "channel i finished".
- PASS_VALUE, 1: value on pass_val_i[i] meaning "channel i passed".
- SETTLE_CYCLES, 1: consecutive matching samples required before a channel latches (≥1).
- TIMEOUT_CYCLES, 0: RUN-state cycle budget; 0 disables the watchdog.
- STOP_ON_FAIL, 0: 1 = first failing channel ends the test immediately.
- CNT_W, 32: cycle counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  start monitoring; sampled only in IDLE.
- done_val_i  in  NUM_CH×DATA_W  per-channel done value.
- pass_val_i  in  NUM_CH×DATA_W  per-channel pass value.
- test_done_o  out  1  terminal state reached (PASS, FAIL or TIMEOUT).
- test_pass_o  out  1  state == PASS.
- test_fail_o  out  1  state == FAIL.
- test_timeout_o  out  1  state == TIMEOUT.
- finish_req_o  out  1  harness may call $finish.
- done_mask_o  out  NUM_CH  channels latched.
- fail_mask_o  out  NUM_CH  channels latched as failed.
- cycle_count_o  out  CNT_W  edges spent in RUN, saturating.

## Operation

- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset.
- IDLE→RUN on an edge with enable_i=1. enable_i is ignored outside IDLE.
- Per channel, in RUN only:
  - Settle counter increments on an edge where done_val_i[i]==DONE_VALUE, and clears to 0 on a mismatch.
  - On the edge where the counter reaches SETTLE_CYCLES, set done_mask_o[i]. On that same edge set fail_mask_o[i] = (pass_val_i[i] != PASS_VALUE).
  - A latched channel is frozen; later input changes are ignored.
- RUN exit, evaluated on each edge from registered masks, in priority order:
  1. All done_mask bits set: go to FAIL if any fail_mask bit is set, else PASS.
  2. STOP_ON_FAIL=1 and any fail_mask bit set: go to FAIL.
  3. TIMEOUT_CYCLES≠0 and cycle_count_o==TIMEOUT_CYCLES: go to TIMEOUT.
- Completion beats timeout on the same edge.
- cycle_count_o increments each RUN edge, saturates at 2^CNT_W−1, and holds in terminal states.
- Simulation only, excluded from synthesis: one $display of verdict, masks and cycle count on terminal entry, never repeated.

## Timing

- Reset values: state IDLE; all outputs 0; all counters and masks 0.
- Channel latency: done_val_i matching from sampling edge k latches at edge k+SETTLE_CYCLES−1.
- Verdict latency: verdict outputs rise one edge after the last required mask bit is set.
- finish_req_o rises one edge after terminal entry and stays high.
- Timeout: TIMEOUT entered at the edge after cycle_count_o reaches TIMEOUT_CYCLES, i.e. cycle_count_o reads TIMEOUT_CYCLES in TIMEOUT.
- Reset during any state returns everything to reset values asynchronously. Monitoring resumes only after a new enable_i.
- Verdict outputs are registered with no combinational input-to-output paths.

## Structure

- Package sim_test_pkg holds:
  - test_state_e enum (IDLE, RUN, PASS, FAIL, TIMEOUT);
  - localparam helper for settle counter width, $clog2(SETTLE_CYCLES+1).
- Sub-module sim_test_chan: one channel's settle counter and done/fail latch, generated NUM_CH times.
- Top holds the FSM, cycle counter, finish delay flop and $display.

## Test plan

- NUM_CH=1, SETTLE_CYCLES=1: enable at edge 0, done_val=1 and pass_val=1 from edge 10.
  -> done_mask_o=1 at edge 10; test_pass_o at edge 11; finish_req_o at edge 12; cycle_count_o holds 11.
- SETTLE_CYCLES=4: done_val=1 for 3 edges, 0 for 1 edge, then 1 from edge 20 with pass_val=5.
  -> no latch from the first run; latch at edge 23; test_fail_o at edge 24; fail_mask_o=1.
- NUM_CH=2, STOP_ON_FAIL=0: ch0 passes at edge 20, ch1 fails at edge 40.
  -> FAIL at edge 41; done_mask_o=2'b11; fail_mask_o=2'b10.
- NUM_CH=2, STOP_ON_FAIL=1: ch1 fails at edge 20, ch0 never done.
  -> FAIL at edge 21; done_mask_o=2'b10.
- TIMEOUT_CYCLES=100, done never asserted.
  -> test_timeout_o after 100 RUN edges, cycle_count_o=100.
  -> With CNT_W=4 and TIMEOUT_CYCLES=0: count saturates at 15 and no verdict is given.
- Channel completes on exactly the edge the timeout fires -> PASS, not TIMEOUT.
  Then assert rst_ni mid-RUN in a second run -> all outputs 0 immediately; no verdict until enable_i is re-asserted.

Source files
------------

// File: rtl/sim_test_pkg.sv
// Shared types and helpers for the end-of-test monitor.
package sim_test_pkg;

  // Monitor lifecycle. PASS, FAIL and TIMEOUT are terminal and sticky until reset.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } test_state_e;

  // Width of a settle counter that must be able to hold SETTLE_CYCLES itself.
  function automatic int unsigned settle_cnt_w(input int unsigned settle_cycles);
    return (settle_cycles < 2) ? 1 : $clog2(settle_cycles + 1);
  endfunction

  // True for the three verdict states.
  function automatic logic is_terminal(input test_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sim_test_chan.sv
// One monitored channel: counts consecutive "done" samples while the monitor
// runs and, once the settle window is met, latches done plus a pass/fail flag.
// A latched channel ignores its inputs until reset.
module sim_test_chan
  import sim_test_pkg::*;
#(
  parameter int unsigned       DATA_W        = 32,
  parameter logic [DATA_W-1:0] DONE_VALUE    = DATA_W'(1),
  parameter logic [DATA_W-1:0] PASS_VALUE    = DATA_W'(1),
  parameter int unsigned       SETTLE_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run,
  input  logic [DATA_W-1:0] done_val,
  input  logic [DATA_W-1:0] pass_val,
  output logic              done,
  output logic              fail
);

  localparam int unsigned   CW   = settle_cnt_w(SETTLE_CYCLES);
  // Counter value seen on the edge whose matching sample completes the window.
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] settle_cnt;
  logic          match;

  assign match = (done_val == DONE_VALUE);

  // Settle counter and done/fail latch; only advances in RUN and before latching.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_cnt <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else if (run && !done) begin
      if (match) begin
        settle_cnt <= settle_cnt + 1'b1;
        if (settle_cnt == LAST) begin
          done <= 1'b1;
          fail <= (pass_val != PASS_VALUE);
        end
      end else begin
        settle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sim_test_monitor.sv
// End-of-test monitor for the simulation top. Watches per-hart done/pass
// values through a settle window, runs an optional watchdog, and reports one
// sticky verdict plus a delayed finish request for the C++ harness.
module sim_test_monitor
  import sim_test_pkg::*;
#(
  parameter int unsigned       NUM_CH         = 1,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [DATA_W-1:0] DONE_VALUE     = DATA_W'(1),
  parameter logic [DATA_W-1:0] PASS_VALUE     = DATA_W'(1),
  parameter int unsigned       SETTLE_CYCLES  = 1,
  parameter int unsigned       TIMEOUT_CYCLES = 0,
  parameter bit                STOP_ON_FAIL   = 1'b0,
  parameter int unsigned       CNT_W          = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  done_val_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  pass_val_i,
  output logic                           test_done_o,
  output logic                           test_pass_o,
  output logic                           test_fail_o,
  output logic                           test_timeout_o,
  output logic                           finish_req_o,
  output logic [NUM_CH-1:0]              done_mask_o,
  output logic [NUM_CH-1:0]              fail_mask_o,
  output logic [CNT_W-1:0]               cycle_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  test_state_e      state_q;
  test_state_e      state_d;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic             finish_q;
  logic             run;
  logic             all_done;
  logic             any_fail;
  logic             timeout_hit;

  assign run         = (state_q == ST_RUN);
  assign all_done    = &done_mask_o;
  assign any_fail    = |fail_mask_o;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt_q == TIMEOUT_CNT);

  // Per-channel settle filters; their latches form the registered masks.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    sim_test_chan #(
      .DATA_W        (DATA_W),
      .DONE_VALUE    (DONE_VALUE),
      .PASS_VALUE    (PASS_VALUE),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .run      (run),
      .done_val (done_val_i[g]),
      .pass_val (pass_val_i[g]),
      .done     (done_mask_o[g]),
      .fail     (fail_mask_o[g])
    );
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: completion outranks stop-on-fail, which outranks the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (all_done) begin
          state_d = any_fail ? ST_FAIL : ST_PASS;
        end else if (STOP_ON_FAIL && any_fail) begin
          state_d = ST_FAIL;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Cycle count advances on RUN edges, saturates, and stays on the budget
  // value when the watchdog fires so it reads TIMEOUT_CYCLES afterwards.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (run && (state_d != ST_TIMEOUT) && (cycle_cnt_q != CNT_MAX)) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Finish request trails terminal entry by one edge so the verdict is visible first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      finish_q <= 1'b0;
    end else begin
      finish_q <= is_terminal(state_q);
    end
  end

  assign test_pass_o    = (state_q == ST_PASS);
  assign test_fail_o    = (state_q == ST_FAIL);
  assign test_timeout_o = (state_q == ST_TIMEOUT);
  assign test_done_o    = test_pass_o | test_fail_o | test_timeout_o;
  assign finish_req_o   = finish_q;
  assign cycle_count_o  = cycle_cnt_q;

`ifndef SYNTHESIS
  function automatic string verdict_name(input test_state_e s);
    case (s)
      ST_PASS: return "pass";
      ST_FAIL: return "fail";
      ST_TIMEOUT: return "timeout";
      default: return "none";
    endcase
  endfunction

  // Report once: the edge after terminal entry is the only one with done high and finish low.
  always_ff @(posedge clk_i) begin
    if (rst_ni && test_done_o && !finish_q) begin
      $display("sim_test_monitor: verdict=%s done_mask=%b fail_mask=%b cycles=%0d",
               verdict_name(state_q), done_mask_o, fail_mask_o, cycle_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_sim_test_monitor.sv
// Bench for sim_test_monitor: a table-driven settle/fail sequence, hand-written
// corner sequences (timeout, completion vs timeout, async reset, saturation,
// stop-on-fail) and randomized runs scored by a trace-level reference model.
`timescale 1ns/1ps
module tb_sim_test_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT P: 2 ch, settle 4, timeout 100 ----------------
  logic              rst_p, en_p;
  logic [1:0][31:0]  dv_p, pv_p;
  logic              td_p, tp_p, tf_p, tt_p, fr_p;
  logic [1:0]        dm_p, fm_p;
  logic [31:0]       cnt_p;

  sim_test_monitor #(
    .NUM_CH(2), .DATA_W(32), .DONE_VALUE(32'd1), .PASS_VALUE(32'd1),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100), .STOP_ON_FAIL(1'b0), .CNT_W(32)
  ) u_p (
    .clk_i(clk), .rst_ni(rst_p), .enable_i(en_p),
    .done_val_i(dv_p), .pass_val_i(pv_p),
    .test_done_o(td_p), .test_pass_o(tp_p), .test_fail_o(tf_p),
    .test_timeout_o(tt_p), .finish_req_o(fr_p),
    .done_mask_o(dm_p), .fail_mask_o(fm_p), .cycle_count_o(cnt_p)
  );

  // ---------------- DUT S: 2 ch, settle 1, stop-on-fail, 4-bit count ----------------
  logic              rst_s, en_s;
  logic [1:0][31:0]  dv_s, pv_s;
  logic              td_s, tp_s, tf_s, tt_s, fr_s;
  logic [1:0]        dm_s, fm_s;
  logic [3:0]        cnt_s;

  sim_test_monitor #(
    .NUM_CH(2), .DATA_W(32), .DONE_VALUE(32'd1), .PASS_VALUE(32'd1),
    .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(0), .STOP_ON_FAIL(1'b1), .CNT_W(4)
  ) u_s (
    .clk_i(clk), .rst_ni(rst_s), .enable_i(en_s),
    .done_val_i(dv_s), .pass_val_i(pv_s),
    .test_done_o(td_s), .test_pass_o(tp_s), .test_fail_o(tf_s),
    .test_timeout_o(tt_s), .finish_req_o(fr_s),
    .done_mask_o(dm_s), .fail_mask_o(fm_s), .cycle_count_o(cnt_s)
  );

  // ---------------- DUT R: randomized, 3 ch ----------------
  localparam int RS = 3;
  localparam int RT = 40;
  localparam int RN = 45;
  logic              rst_r, en_r;
  logic [2:0][3:0]   dv_r, pv_r;
  logic              td_r, tp_r, tf_r, tt_r, fr_r;
  logic [2:0]        dm_r, fm_r;
  logic [7:0]        cnt_r;

  sim_test_monitor #(
    .NUM_CH(3), .DATA_W(4), .DONE_VALUE(4'd5), .PASS_VALUE(4'd9),
    .SETTLE_CYCLES(RS), .TIMEOUT_CYCLES(RT), .STOP_ON_FAIL(1'b0), .CNT_W(8)
  ) u_r (
    .clk_i(clk), .rst_ni(rst_r), .enable_i(en_r),
    .done_val_i(dv_r), .pass_val_i(pv_r),
    .test_done_o(td_r), .test_pass_o(tp_r), .test_fail_o(tf_r),
    .test_timeout_o(tt_r), .finish_req_o(fr_r),
    .done_mask_o(dm_r), .fail_mask_o(fm_r), .cycle_count_o(cnt_r)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Status word: {done_mask, fail_mask, done, pass, fail, timeout, finish}
  function automatic logic [8:0] st_p();
    return {dm_p, fm_p, td_p, tp_p, tf_p, tt_p, fr_p};
  endfunction
  function automatic logic [8:0] st_s();
    return {dm_s, fm_s, td_s, tp_s, tf_s, tt_s, fr_s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic reset_p();
    rst_p = 1'b0; en_p = 1'b0; dv_p = '0; pv_p = '0;
    tick(2);
    rst_p = 1'b1;
    tick(1);
  endtask

  task automatic reset_s();
    rst_s = 1'b0; en_s = 1'b0; dv_s = '0; pv_s = '0;
    tick(2);
    rst_s = 1'b1;
    tick(1);
  endtask

  // ---------------- table for DUT P ----------------
  typedef struct {
    int          reps;
    logic [1:0]  dbits;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [8:0]  exp_st;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[11];

  // ---------------- random trace storage ----------------
  logic [2:0][3:0] tr_dv [RN+1];
  logic [2:0][3:0] tr_pv [RN+1];

  initial begin
    rst_p = 1'b0; en_p = 1'b0; dv_p = '0; pv_p = '0;
    rst_s = 1'b0; en_s = 1'b0; dv_s = '0; pv_s = '0;
    rst_r = 1'b0; en_r = 1'b0; dv_r = '0; pv_r = '0;
    tick(2);

    // Reset values of every DUT.
    check("reset_p", {st_p(), cnt_p}, 64'd0);
    check("reset_s", {st_s(), cnt_s}, 64'd0);
    check("reset_r", {dm_r, fm_r, td_r, tp_r, tf_r, tt_r, fr_r, cnt_r}, 64'd0);

    // ---- table: ch1 settles early and passes; ch0 glitches, then settles failing ----
    tbl[0]  = '{3, 2'b10, 32'd0, 32'd1, 9'b00_00_0000_0, 32'd3};
    tbl[1]  = '{1, 2'b10, 32'd0, 32'd1, 9'b10_00_0000_0, 32'd4};
    tbl[2]  = '{5, 2'b00, 32'd0, 32'd7, 9'b10_00_0000_0, 32'd9};
    tbl[3]  = '{3, 2'b01, 32'd5, 32'd7, 9'b10_00_0000_0, 32'd12};
    tbl[4]  = '{1, 2'b00, 32'd5, 32'd7, 9'b10_00_0000_0, 32'd13};
    tbl[5]  = '{6, 2'b00, 32'd5, 32'd7, 9'b10_00_0000_0, 32'd19};
    tbl[6]  = '{3, 2'b01, 32'd5, 32'd7, 9'b10_00_0000_0, 32'd22};
    tbl[7]  = '{1, 2'b01, 32'd5, 32'd7, 9'b11_01_0000_0, 32'd23};
    tbl[8]  = '{1, 2'b00, 32'd5, 32'd7, 9'b11_01_1010_0, 32'd24};
    tbl[9]  = '{1, 2'b00, 32'd5, 32'd7, 9'b11_01_1010_1, 32'd24};
    tbl[10] = '{3, 2'b11, 32'd1, 32'd1, 9'b11_01_1010_1, 32'd24};

    reset_p();
    en_p = 1'b1;
    tick(1);                               // edge 0: IDLE -> RUN
    en_p = 1'b0;
    for (int i = 0; i < 11; i++) begin
      dv_p[0] = tbl[i].dbits[0] ? 32'd1 : 32'h1a;
      dv_p[1] = tbl[i].dbits[1] ? 32'd1 : 32'h0;
      pv_p[0] = tbl[i].p0;
      pv_p[1] = tbl[i].p1;
      tick(tbl[i].reps);
      check($sformatf("p_tbl[%0d]", i), {st_p(), cnt_p}, {tbl[i].exp_st, tbl[i].exp_cnt});
    end

    // ---- P: watchdog fires after 100 RUN edges ----
    reset_p();
    en_p = 1'b1; tick(1); en_p = 1'b0;
    tick(100);
    check("p_to_edge100", {st_p(), cnt_p}, {9'b00_00_0000_0, 32'd100});
    tick(1);
    check("p_to_entry", {st_p(), cnt_p}, {9'b00_00_1001_0, 32'd100});
    tick(1);
    check("p_to_finish", {st_p(), cnt_p}, {9'b00_00_1001_1, 32'd100});
    tick(5);
    check("p_to_sticky", {st_p(), cnt_p}, {9'b00_00_1001_1, 32'd100});

    // ---- P: completion on the timeout edge wins ----
    reset_p();
    en_p = 1'b1; tick(1); en_p = 1'b0;
    tick(96);
    dv_p = {32'd1, 32'd1}; pv_p = {32'd1, 32'd1};
    tick(4);
    check("p_race_latched", {st_p(), cnt_p}, {9'b11_00_0000_0, 32'd100});
    tick(1);
    check("p_race_pass", {st_p(), cnt_p}, {9'b11_00_1100_0, 32'd101});
    tick(1);
    check("p_race_finish", {st_p(), cnt_p}, {9'b11_00_1100_1, 32'd101});

    // ---- P: asynchronous reset mid-RUN, then no activity until re-enable ----
    reset_p();
    en_p = 1'b1; tick(1); en_p = 1'b0;
    dv_p = {32'd1, 32'd0}; pv_p = {32'd1, 32'd0};
    tick(6);
    check("p_pre_reset", {st_p(), cnt_p}, {9'b10_00_0000_0, 32'd6});
    #2 rst_p = 1'b0;
    #1;
    check("p_async_reset", {st_p(), cnt_p}, 64'd0);
    @(posedge clk); #3 rst_p = 1'b1;
    dv_p = {32'd1, 32'd1}; pv_p = {32'd1, 32'd1};
    tick(10);
    check("p_no_enable", {st_p(), cnt_p}, 64'd0);
    en_p = 1'b1; tick(1); en_p = 1'b0;
    tick(4);
    check("p_rerun_latch", {st_p(), cnt_p}, {9'b11_00_0000_0, 32'd4});
    tick(1);
    check("p_rerun_pass", {st_p(), cnt_p}, {9'b11_00_1100_0, 32'd5});

    // ---- S: single-edge settle, pass path ----
    reset_s();
    en_s = 1'b1; tick(1); en_s = 1'b0;
    tick(9);
    dv_s = {32'd1, 32'd1}; pv_s = {32'd1, 32'd1};
    tick(1);
    check("s_latch_edge10", {st_s(), 32'(cnt_s)}, {9'b11_00_0000_0, 32'd10});
    tick(1);
    check("s_pass_edge11", {st_s(), 32'(cnt_s)}, {9'b11_00_1100_0, 32'd11});
    tick(1);
    check("s_finish_edge12", {st_s(), 32'(cnt_s)}, {9'b11_00_1100_1, 32'd11});

    // ---- S: stop on first failure with ch0 never done; counter saturated ----
    reset_s();
    en_s = 1'b1; tick(1); en_s = 1'b0;
    tick(19);
    dv_s = {32'd1, 32'd0}; pv_s = {32'd0, 32'd1};
    tick(1);
    check("s_stop_latch", {st_s(), 32'(cnt_s)}, {9'b10_10_0000_0, 32'd15});
    tick(1);
    check("s_stop_fail", {st_s(), 32'(cnt_s)}, {9'b10_10_1010_0, 32'd15});
    tick(1);
    check("s_stop_finish", {st_s(), 32'(cnt_s)}, {9'b10_10_1010_1, 32'd15});

    // ---- S: no watchdog; count saturates at 15 with no verdict ----
    reset_s();
    en_s = 1'b1; tick(1); en_s = 1'b0;
    tick(14);
    check("s_cnt14", {st_s(), 32'(cnt_s)}, {9'b0, 32'd14});
    tick(1);
    check("s_cnt15", {st_s(), 32'(cnt_s)}, {9'b0, 32'd15});
    tick(15);
    check("s_cnt_sat", {st_s(), 32'(cnt_s)}, {9'b0, 32'd15});

    // ---- R: randomized runs scored by a trace-level model ----
    for (int trial = 0; trial < 20; trial++) begin
      int        pct[3];
      int        latch[3];
      logic      fbit[3];
      int        run_len;
      int        e_exit;
      int        kind;
      int        ecnt;
      int        lim;
      bit        all_d;
      bit        any_f;
      logic [2:0] edm;
      logic [2:0] efm;
      logic       term;

      for (int c = 0; c < 3; c++) begin
        case ($urandom_range(0, 3))
          0: pct[c] = 10;
          1: pct[c] = 45;
          2: pct[c] = 80;
          default: pct[c] = 97;
        endcase
      end
      for (int e = 1; e <= RN; e++) begin
        for (int c = 0; c < 3; c++) begin
          tr_dv[e][c] = ($urandom_range(0, 99) < pct[c]) ? 4'd5 : 4'(5 + $urandom_range(1, 15));
          tr_pv[e][c] = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'(9 + $urandom_range(1, 15));
        end
      end

      // Channel i latches on the first edge closing RS consecutive done samples.
      for (int c = 0; c < 3; c++) begin
        latch[c] = 1000;
        fbit[c]  = 1'b0;
        run_len  = 0;
        for (int e = 1; e <= RN; e++) begin
          run_len = (tr_dv[e][c] == 4'd5) ? run_len + 1 : 0;
          if (run_len == RS && latch[c] == 1000) begin
            latch[c] = e;
            fbit[c]  = (tr_pv[e][c] != 4'd9);
          end
        end
      end
      // Exit edge: completion seen from masks latched on earlier edges, else watchdog.
      e_exit = 0;
      kind   = 0;
      for (int e = 1; e <= RN; e++) begin
        if (e_exit == 0) begin
          all_d = 1'b1;
          any_f = 1'b0;
          for (int c = 0; c < 3; c++) begin
            if (latch[c] < e) any_f = any_f | fbit[c];
            else all_d = 1'b0;
          end
          if (all_d) begin
            e_exit = e;
            kind   = any_f ? 2 : 1;
          end else if (e - 1 == RT) begin
            e_exit = e;
            kind   = 3;
          end
        end
      end

      rst_r = 1'b0; en_r = 1'b0;
      tick(1);
      rst_r = 1'b1;
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 3; c++) begin
          dv_r[c] = 4'($urandom_range(0, 15));
          pv_r[c] = 4'($urandom_range(0, 15));
        end
        tick(1);
        check("r_idle", {dm_r, fm_r, td_r, tp_r, tf_r, tt_r, fr_r, cnt_r}, 64'd0);
      end
      en_r = 1'b1;
      tick(1);
      for (int t = 1; t <= RN; t++) begin
        dv_r = tr_dv[t];
        pv_r = tr_pv[t];
        en_r = 1'($urandom_range(0, 1));
        tick(1);
        lim  = (t < e_exit) ? t : e_exit;
        term = (t >= e_exit);
        for (int c = 0; c < 3; c++) begin
          edm[c] = (latch[c] <= lim);
          efm[c] = edm[c] & fbit[c];
        end
        ecnt = (t < e_exit) ? t : ((kind == 3) ? RT : e_exit);
        check($sformatf("r_trial%0d_edge%0d", trial, t),
              {dm_r, fm_r, td_r, tp_r, tf_r, tt_r, fr_r, cnt_r},
              {edm, efm, term, term && kind == 1, term && kind == 2, term && kind == 3,
               (t >= e_exit + 1), 8'(ecnt)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
